f_fetch_stage: RTL and testbench

//  Fetch (F) stage of the 5-stage MIPS pipeline, directly upstream of the D pipeline register.

---
 rtl/f_fetch_stage_pkg.sv | 30 +++
 rtl/f_fetch_stage_pc_reg.sv | 35 +++
 rtl/f_fetch_stage.sv | 71 +++++++
 tb/tb_f_fetch_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/f_fetch_stage_pkg.sv
// Shared fetch-stage constants, payload type and address-legality helper.
// Reused by the D pipeline register and CP0.
package f_fetch_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [XLEN-1:0]  RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [XLEN-1:0]  EXC_ENTRY_DEF = 32'h0000_4180;
  localparam logic [XLEN-1:0]  IM_BASE_DEF   = 32'h0000_3000;
  localparam logic [XLEN-1:0]  IM_LIMIT_DEF  = 32'h0000_6FFF;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [EXC_W-1:0] exc_code;
    logic             bd;
  } f_to_d_t;

  // Misaligned or outside the instruction-memory window.
  function automatic logic fetch_fault(input logic [XLEN-1:0] pc,
                                       input logic [XLEN-1:0] base,
                                       input logic [XLEN-1:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/f_fetch_stage_pc_reg.sv
// PC register with the prioritised next-PC selection:
// reset > req > stall > eret_d > redirect_d > pc+4.
module f_fetch_stage_pc_reg
  import f_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            stall,
  input  logic            eret_d,
  input  logic [XLEN-1:0] epc,
  input  logic            redirect_d,
  input  logic [XLEN-1:0] target_d,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] next_pc;

  always_comb begin
    next_pc = pc + XLEN'(4);
    if (req)             next_pc = EXC_ENTRY;
    else if (stall)      next_pc = pc;
    else if (eret_d)     next_pc = epc;
    else if (redirect_d) next_pc = target_d;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

endmodule

// File: rtl/f_fetch_stage.sv
// MIPS fetch stage: owns the PC, drives instruction memory, flags fetch AdEL
// and squashes the word following an eret before it reaches the D register.
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter logic [XLEN-1:0] IM_BASE   = IM_BASE_DEF,
  parameter logic [XLEN-1:0] IM_LIMIT  = IM_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             eret_d,
  input  logic [XLEN-1:0]  epc,
  input  logic             redirect_d,
  input  logic [XLEN-1:0]  target_d,
  input  logic             cf_d,
  output logic [XLEN-1:0]  i_inst_addr,
  input  logic [XLEN-1:0]  i_inst_rdata,
  output logic [XLEN-1:0]  instr_f,
  output logic [XLEN-1:0]  pc_f,
  output logic [EXC_W-1:0] exc_code_f,
  output logic             bd_f
);

  logic [XLEN-1:0] pc;
  logic            fault;
  logic            squash;
  f_to_d_t         to_d;

  f_fetch_stage_pc_reg #(
    .RESET_PC  (RESET_PC),
    .EXC_ENTRY (EXC_ENTRY)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .stall      (stall),
    .eret_d     (eret_d),
    .epc        (epc),
    .redirect_d (redirect_d),
    .target_d   (target_d),
    .pc         (pc)
  );

  assign fault  = fetch_fault(pc, IM_BASE, IM_LIMIT);
  // eret has no delay slot: the word behind it is discarded once D advances.
  assign squash = eret_d & ~stall;

  always_comb begin
    to_d.pc       = pc;
    to_d.instr    = i_inst_rdata;
    to_d.exc_code = EXC_NONE;
    to_d.bd       = cf_d & ~eret_d;
    if (squash) begin
      to_d.instr = '0;
    end else if (fault) begin
      to_d.instr    = '0;
      to_d.exc_code = EXC_ADEL;
    end
  end

  assign i_inst_addr = pc;
  assign instr_f     = to_d.instr;
  assign pc_f        = to_d.pc;
  assign exc_code_f  = to_d.exc_code;
  assign bd_f        = to_d.bd;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed vector bench for f_fetch_stage with a behavioural instruction memory.
module tb_f_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        stall;
  logic        eret_d;
  logic [31:0] epc;
  logic        redirect_d;
  logic [31:0] target_d;
  logic        cf_d;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [4:0]  exc_code_f;
  logic        bd_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  f_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .stall        (stall),
    .eret_d       (eret_d),
    .epc          (epc),
    .redirect_d   (redirect_d),
    .target_d     (target_d),
    .cf_d         (cf_d),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .instr_f      (instr_f),
    .pc_f         (pc_f),
    .exc_code_f   (exc_code_f),
    .bd_f         (bd_f)
  );

  typedef struct {
    logic        req;
    logic        stall;
    logic        eret;
    logic [31:0] epc;
    logic        redir;
    logic [31:0] tgt;
    logic        cf;
    logic [31:0] exp_pc;
    logic        exp_zero;
    logic [4:0]  exp_exc;
    logic        exp_bd;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rq, input logic st, input logic er,
                              input logic [31:0] ep, input logic rd,
                              input logic [31:0] tg, input logic cf,
                              input logic [31:0] pc, input logic z,
                              input logic [4:0] exc, input logic bd);
    vec_t v;
    v.req = rq; v.stall = st; v.eret = er; v.epc = ep; v.redir = rd;
    v.tgt = tg; v.cf = cf; v.exp_pc = pc; v.exp_zero = z;
    v.exp_exc = exc; v.exp_bd = bd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    req = 0; stall = 0; eret_d = 0; epc = '0;
    redirect_d = 0; target_d = '0; cf_d = 0;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] pc,
                               input logic z, input logic [4:0] exc,
                               input logic bd);
    check({tag, "_pc"},    pc_f, pc);
    check({tag, "_addr"},  i_inst_addr, pc);
    check({tag, "_instr"}, instr_f, z ? 32'h0 : mem_word(pc));
    check({tag, "_exc"},   32'(exc_code_f), 32'(exc));
    check({tag, "_bd"},    32'(bd_f), 32'(bd));
  endtask

  initial begin
    //            req st er epc           rd tgt           cf pc            z  exc  bd
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 5'd0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0, 5'd0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 0, 5'd0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_300C, 0, 5'd0, 0);
    vecs[4]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 0, 5'd0, 0);
    vecs[5]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 0, 5'd0, 0);
    vecs[6]  = mk(0, 1, 0, 32'h0,        1, 32'h0000_5000, 1, 32'h0000_3010, 0, 5'd0, 1);
    vecs[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 0, 5'd0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3014, 0, 5'd0, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3018, 0, 5'd0, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_301C, 0, 5'd0, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,        1, 32'h0000_3100, 1, 32'h0000_3020, 0, 5'd0, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3100, 0, 5'd0, 0);
    vecs[13] = mk(0, 0, 0, 32'h0,        1, 32'h0000_3102, 1, 32'h0000_3104, 0, 5'd0, 1);
    vecs[14] = mk(0, 0, 0, 32'h0,        1, 32'h0000_7000, 1, 32'h0000_3102, 1, 5'd4, 1);
    vecs[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_7000, 1, 5'd4, 0);
    vecs[16] = mk(0, 0, 0, 32'h0,        1, 32'h0000_6FFC, 1, 32'h0000_7004, 1, 5'd4, 1);
    vecs[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_6FFC, 0, 5'd0, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,        1, 32'h0000_2FFC, 1, 32'h0000_7000, 1, 5'd4, 1);
    vecs[19] = mk(0, 0, 0, 32'h0,        1, 32'h0000_3030, 1, 32'h0000_2FFC, 1, 5'd4, 1);
    vecs[20] = mk(0, 0, 1, 32'h0000_3040, 0, 32'h0,       1, 32'h0000_3030, 1, 5'd0, 0);
    vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3040, 0, 5'd0, 0);
    vecs[22] = mk(0, 1, 1, 32'h0000_3200, 0, 32'h0,       0, 32'h0000_3044, 0, 5'd0, 0);
    vecs[23] = mk(1, 1, 1, 32'h0000_3200, 0, 32'h0,       0, 32'h0000_3044, 0, 5'd0, 0);
    vecs[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4180, 0, 5'd0, 0);
    vecs[25] = mk(0, 0, 1, 32'h0000_3300, 1, 32'h0000_5000, 0, 32'h0000_4184, 1, 5'd0, 0);
    vecs[26] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3300, 0, 5'd0, 0);
    vecs[27] = mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h0000_3304, 0, 5'd0, 1);
    vecs[28] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 1, 5'd4, 0);
    vecs[29] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 5'd4, 0);
    vecs[30] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 1, 5'd4, 0);

    reset = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 32'h0000_3000, 1'b0, 5'd0, 1'b0);
    reset = 0;

    for (int i = 0; i < NV; i++) begin
      req = vecs[i].req; stall = vecs[i].stall; eret_d = vecs[i].eret;
      epc = vecs[i].epc; redirect_d = vecs[i].redir;
      target_d = vecs[i].tgt; cf_d = vecs[i].cf;
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_zero,
                    vecs[i].exp_exc, vecs[i].exp_bd);
      @(negedge clk);
    end

    // Reset asserted mid-run alongside a pending redirect and eret.
    drive_idle();
    check("pre_reset_pc", pc_f, 32'h0000_0008);
    reset = 1; redirect_d = 1; target_d = 32'h0000_3500;
    eret_d = 1; epc = 32'h0000_3600; req = 1;
    @(negedge clk);
    drive_idle();
    #1;
    check_outputs("midreset", 32'h0000_3000, 1'b0, 5'd0, 1'b0);
    reset = 0;
    @(negedge clk);
    check_outputs("post_reset", 32'h0000_3004, 1'b0, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
